apb_master: RTL and testbench

//  APB initiator bridging a simple request/response port (CPU/bus core side) to up to
//  NUM_SLV APB slaves such as the GPIO peripheral. Runs IDLE/SETUP/ACCESS, decodes the

---
 rtl/apb_master.sv | 123 ++++++++++++
 tb/tb_apb_master.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB initiator: turns single request/response transactions into APB SETUP/ACCESS
// transfers on one of NUM_SLV address-decoded slaves, with a PREADY timeout.
module apb_master #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] SLV_SPAN  = 32'h0000_1000,
    parameter int          TIMEOUT   = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic [31:0]             PADDR,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    output logic                    PENABLE,
    output logic [NUM_SLV-1:0]      PSEL,
    input  logic [NUM_SLV*32-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY
);
    localparam int          IW     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int          CW     = $clog2(TIMEOUT + 1);
    localparam logic [32:0] SPAN33 = {1'b0, SLV_SPAN};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] sel_idx, dec_idx;
    logic [CW-1:0] cnt;
    logic [31:0]   off, dec_base, sel_rdata;
    logic          hit, sel_ready, tmo;

    // Range decode; 33-bit compares keep the top slave window from wrapping.
    always_comb begin
        off      = req_addr - BASE_ADDR;
        hit      = 1'b0;
        dec_idx  = '0;
        dec_base = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (req_addr >= BASE_ADDR &&
                {1'b0, off} >= 33'(i) * SPAN33 &&
                {1'b0, off} <  33'(i + 1) * SPAN33) begin
                hit      = 1'b1;
                dec_idx  = IW'(i);
                dec_base = 32'(i) * SLV_SPAN;
            end
        end
    end

    assign sel_ready = PREADY[sel_idx];
    assign sel_rdata = PRDATA[32*sel_idx +: 32];
    assign tmo       = (cnt == CW'(TIMEOUT - 1));
    assign req_ready = (state == IDLE);
    assign PENABLE   = (state == ACCESS);

    always_comb begin
        PSEL = '0;
        if (state != IDLE) PSEL[sel_idx] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid && hit) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (sel_ready || tmo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            sel_idx   <= '0;
            cnt       <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    if (hit) begin
                        sel_idx <= dec_idx;
                        PADDR   <= off - dec_base;
                        PWRITE  <= req_write;
                        PWDATA  <= req_wdata;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? 32'h0 : sel_rdata;
                        cnt       <= '0;
                    end else if (tmo) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: behavioural slaves with programmable wait states,
// scoreboard of expected responses, latency / select / protocol checks.
module tb_apb_master;
    localparam int N = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid, req_ready, req_write;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [31:0]       PADDR, PWDATA;
    logic              PWRITE, PENABLE;
    logic [N-1:0]      PSEL, PREADY;
    logic [N*32-1:0]   PRDATA;

    apb_master dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { logic err; logic [31:0] rdata; } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, acc_cnt = 0;
    int wt [N];
    logic [31:0] rd [N];
    logic [N-1:0] stray;
    logic got_rsp;
    int rsp_cyc;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave side: PREADY rises wt[i] cycles into ACCESS; stray forces a lane high.
    always @(posedge PCLK or posedge PRESET)
        if (PRESET) acc_cnt <= 0;
        else        acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        PREADY = '0;
        PRDATA = '0;
        for (int i = 0; i < N; i++) begin
            PREADY[i] = stray[i] | (PSEL[i] & PENABLE & (acc_cnt >= wt[i]));
            PRDATA[32*i +: 32] = rd[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge PCLK);
        got_rsp = 1'b0;
        if ($countones(PSEL) > 1 || (PENABLE && PSEL == '0))
            chk("psel_onehot_penable", {PENABLE, 27'd0, PSEL}, 32'h0);
        if (rsp_valid) begin
            got_rsp = 1'b1;
            rsp_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    endtask

    task automatic wait_rsp(input int budget, input string tag);
        int k;
        k = 0;
        do begin step(); k++; end while (!got_rsp && k < budget);
        if (!got_rsp) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    // Caller is at a negedge with the DUT in IDLE.
    task automatic run(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input int e_lat, input logic [N-1:0] e_psel,
                       input logic [31:0] e_paddr, input int e_acc);
        exp_t e;
        int c0, setups, accs, k;
        logic [N-1:0] seen;
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        e.err = e_err; e.rdata = e_rd; sb.push_back(e);
        c0 = cyc; setups = 0; accs = 0; seen = '0; k = 0;
        do begin
            step();
            req_valid = 1'b0;
            if (PSEL != '0) begin
                seen |= PSEL;
                if (PENABLE) accs++; else setups++;
            end
            k++;
        end while (!got_rsp && k < 40);
        if (!got_rsp) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        chk({tag, "_latency"}, rsp_cyc - c0, e_lat);
        chk({tag, "_psel_seen"}, 32'(seen), 32'(e_psel));
        chk({tag, "_setup_cycles"}, setups, (e_psel != '0) ? 1 : 0);
        chk({tag, "_access_cycles"}, accs, e_acc);
        chk({tag, "_idle_at_rsp"}, {30'd0, PENABLE, req_ready}, 32'd1);
        chk({tag, "_psel_at_rsp"}, 32'(PSEL), 32'd0);
        if (e_psel != '0) begin
            chk({tag, "_paddr"}, PADDR, e_paddr);
            chk({tag, "_pwrite"}, {31'd0, PWRITE}, {31'd0, w});
            if (w) chk({tag, "_pwdata"}, PWDATA, wd);
        end
    endtask

    initial begin
        exp_t e;
        int c0;
        PRESET = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        stray = '0;
        for (int i = 0; i < N; i++) begin wt[i] = 0; rd[i] = 32'hA000_0000 + i; end
        repeat (2) @(negedge PCLK);
        chk("rst_outputs", {26'd0, req_ready, rsp_valid, rsp_err, PENABLE, PWRITE, |PSEL}, 32'h20);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        PRESET = 1'b0;
        step();

        wt[0] = 1;
        run("t1_write", 1, 32'h1000_0004, 32'h0000_00A5, 0, 32'h0, 4, 4'b0001, 32'h4, 2);
        step();
        wt[2] = 0; rd[2] = 32'h0000_003C;
        run("t2_read", 0, 32'h1000_2008, 32'h0, 0, 32'h3C, 3, 4'b0100, 32'h8, 1);
        step();
        chk("t2_rdata_held", rsp_rdata, 32'h3C);
        run("t3_unmapped_high", 0, 32'h2000_0000, 32'h0, 1, 32'h0, 1, 4'b0000, 32'h0, 0);
        step();
        run("t3_below_base", 0, 32'h0FFF_FFFC, 32'h0, 1, 32'h0, 1, 4'b0000, 32'h0, 0);
        step();
        run("t3_past_top", 1, 32'h1000_4000, 32'h1, 1, 32'h0, 1, 4'b0000, 32'h0, 0);
        step();
        wt[3] = 0; rd[3] = 32'h0000_BEEF;
        run("top_window", 0, 32'h1000_3FFC, 32'h0, 0, 32'hBEEF, 3, 4'b1000, 32'hFFC, 1);
        step();
        wt[1] = 1000; rd[1] = 32'h1234_5678;
        run("t4_timeout", 0, 32'h1000_1010, 32'h0, 1, 32'h0, 18, 4'b0010, 32'h10, 16);
        step();

        // Back-to-back with a stray PREADY on an unselected lane.
        stray = 4'b0001; rd[0] = 32'hDEAD_0000;
        wt[3] = 1; rd[3] = 32'hCAFE_0003; wt[1] = 0;
        req_valid = 1; req_write = 0; req_addr = 32'h1000_3000; req_wdata = 0;
        e.err = 0; e.rdata = 32'hCAFE_0003; sb.push_back(e);
        c0 = cyc;
        step();
        req_write = 1; req_addr = 32'h1000_1000; req_wdata = 32'h55;
        e.err = 0; e.rdata = 32'h0; sb.push_back(e);
        wait_rsp(20, "t5_first");
        chk("t5_first_latency", rsp_cyc - c0, 4);
        chk("t5_ready_in_rsp_cycle", {31'd0, req_ready}, 32'd1);
        c0 = cyc;
        step();
        req_valid = 0;
        chk("t5_second_setup", {27'd0, PENABLE, PSEL}, 32'h02);
        chk("t5_second_paddr", PADDR, 32'h0);
        wait_rsp(20, "t5_second");
        chk("t5_second_latency", rsp_cyc - c0, 3);
        stray = '0;
        step();

        // Reset in the middle of ACCESS.
        wt[2] = 1000;
        req_valid = 1; req_write = 0; req_addr = 32'h1000_2000;
        step();
        req_valid = 0;
        step();
        chk("t6_in_access", {30'd0, PENABLE, PSEL[2]}, 32'd3);
        #2 PRESET = 1'b1;
        #1;
        chk("t6_reset_abort", {25'd0, rsp_valid, PENABLE, 1'b0, PSEL}, 32'h0);
        chk("t6_ready_in_reset", {31'd0, req_ready}, 32'd1);
        @(posedge PCLK); @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        wt[2] = 0;
        for (int k = 0; k < 20; k++) step();
        chk("t6_ready_after", {31'd0, req_ready}, 32'd1);
        chk("t6_no_rsp_pending", sb.size(), 0);
        rd[0] = 32'h0000_0011; wt[0] = 0;
        run("t6_post_reset", 0, 32'h1000_0000, 32'h0, 0, 32'h11, 3, 4'b0001, 32'h0, 1);
        step();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
